// File: rtl/tsc_mem_port_sequencer.sv
// Arbitrates the single TSC memory port between instruction fetch and data (LWD/SWD) requesters,
// running one read/write handshake at a time with a bounded wait.
module tsc_mem_port_sequencer #(
    parameter int unsigned WORD_SIZE     = 16,
    parameter int unsigned TIMEOUT       = 255,
    parameter int unsigned CNT_W         = 8,
    parameter bit          DATA_PRIORITY = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] rdata,
    output logic                 if_done,
    output logic                 d_done,
    output logic                 err,
    output logic                 busy,
    output logic [WORD_SIZE-1:0] num_access,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput
);

    typedef enum logic [1:0] {StIdle, StReadI, StReadD, StWrite} state_e;

    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);

    state_e               state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_nxt;
    logic                 last_data_q;
    logic [WORD_SIZE-1:0] address_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] rdata_q;
    logic [WORD_SIZE-1:0] num_q;
    logic                 if_done_q;
    logic                 d_done_q;
    logic                 err_q;
    logic                 grant_data;
    logic                 ready;

    // On a tie, round-robin favours whoever was not served last.
    always_comb begin
        grant_data = d_req;
        if (d_req && if_req) begin
            grant_data = DATA_PRIORITY ? 1'b1 : !last_data_q;
        end
    end

    always_comb begin
        ready = 1'b0;
        if (state_q == StWrite) begin
            ready = ackOutput;
        end else if (state_q == StReadI || state_q == StReadD) begin
            ready = inputReady;
        end
    end

    assign cnt_nxt = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            last_data_q <= 1'b0;
            address_q   <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            num_q       <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            if_done_q <= 1'b0;
            d_done_q  <= 1'b0;
            err_q     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (if_req || d_req) begin
                        cnt_q       <= '0;
                        last_data_q <= grant_data;
                        if (grant_data) begin
                            address_q <= d_addr;
                            wdata_q   <= d_wdata;
                            state_q   <= d_we ? StWrite : StReadD;
                        end else begin
                            address_q <= if_addr;
                            state_q   <= StReadI;
                        end
                    end
                end
                StReadI, StReadD, StWrite: begin
                    // Ready beats timeout when both land on the same edge.
                    if (ready) begin
                        if (state_q != StWrite) begin
                            rdata_q <= data;
                        end
                        if_done_q <= (state_q == StReadI);
                        d_done_q  <= (state_q != StReadI);
                        num_q     <= num_q + 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        cnt_q <= cnt_nxt;
                        if (cnt_nxt == TimeoutCnt) begin
                            err_q   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign readM      = (state_q == StReadI) || (state_q == StReadD);
    assign writeM     = (state_q == StWrite);
    assign busy       = (state_q != StIdle);
    assign address    = address_q;
    assign rdata      = rdata_q;
    assign num_access = num_q;
    assign if_done    = if_done_q;
    assign d_done     = d_done_q;
    assign err        = err_q;
    assign data       = writeM ? wdata_q : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_tsc_mem_port_sequencer.sv
// Bench for tsc_mem_port_sequencer: vector table of single accesses plus tie, reset and wrap sequences.
module tb_tsc_mem_port_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic [15:0] rdata, num_access, address;
    logic        if_done, d_done, err, busy, readM, writeM;
    logic        inputReady, ackOutput, mem_drive;
    logic [15:0] mem_data;
    wire  [15:0] data;

    logic        rr_if_req, rr_d_req;
    logic [3:0]  rr_rdata, rr_num, rr_address;
    logic        rr_if_done, rr_d_done, rr_err, rr_busy, rr_readM, rr_writeM;
    wire  [3:0]  rr_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign data    = mem_drive ? mem_data : 16'hzzzz;
    assign rr_data = rr_readM ? ~rr_address : 4'hz;

    tsc_mem_port_sequencer #(
        .WORD_SIZE(16), .TIMEOUT(4), .CNT_W(8), .DATA_PRIORITY(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .d_req(d_req), .d_we(d_we),
        .d_addr(d_addr), .d_wdata(d_wdata), .rdata(rdata), .if_done(if_done), .d_done(d_done),
        .err(err), .busy(busy), .num_access(num_access), .readM(readM), .writeM(writeM),
        .address(address), .data(data), .inputReady(inputReady), .ackOutput(ackOutput)
    );

    tsc_mem_port_sequencer #(
        .WORD_SIZE(4), .TIMEOUT(255), .CNT_W(8), .DATA_PRIORITY(1'b0)
    ) dut_rr (
        .clk(clk), .reset(reset), .if_req(rr_if_req), .if_addr(4'h3), .d_req(rr_d_req),
        .d_we(1'b0), .d_addr(4'h9), .d_wdata(4'h0), .rdata(rr_rdata), .if_done(rr_if_done),
        .d_done(rr_d_done), .err(rr_err), .busy(rr_busy), .num_access(rr_num),
        .readM(rr_readM), .writeM(rr_writeM), .address(rr_address), .data(rr_data),
        .inputReady(1'b1), .ackOutput(1'b0)
    );

    typedef struct {
        logic        is_data;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] mem_rdata;
        int          wait_n;   // non-ready strobe cycles before ready; 99 = never
        logic [2:0]  kind;     // {if_done, d_done, err}
        logic [15:0] rdata;
        logic [15:0] num;
        int          strobes;
    } vec_t;

    typedef struct {
        logic [2:0]  kind;
        logic [15:0] rdata;
        logic [15:0] num;
    } exp_t;

    exp_t exp_q[$];
    exp_t rr_q[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, " unexpected pulse"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, " kind"}, {29'd0, if_done, d_done, err}, {29'd0, e.kind});
            check({tag, " rdata"}, {16'd0, rdata}, {16'd0, e.rdata});
            check({tag, " num_access"}, {16'd0, num_access}, {16'd0, e.num});
        end
    endtask

    task automatic run_access(input vec_t v);
        int cyc;
        int strobes;
        logic wr;
        wr = v.is_data && v.we;
        @(negedge clk);
        if (v.is_data) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            if_req = 1'b1; if_addr = v.addr;
        end
        exp_q.push_back('{kind: v.kind, rdata: v.rdata, num: v.num});
        cyc = 0;
        strobes = 0;
        while (!(if_done || d_done || err) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            inputReady = 1'b0; ackOutput = 1'b0; mem_drive = 1'b0;
            if (readM || writeM) begin
                strobes++;
                check("strobe type", {30'd0, readM, writeM}, {30'd0, !wr, wr});
                check("address", {16'd0, address}, {16'd0, v.addr});
                if (wr) begin
                    check("write bus", {16'd0, data}, {16'd0, v.wdata});
                    inputReady = 1'b1;
                    ackOutput  = (strobes == v.wait_n + 1);
                end else begin
                    ackOutput  = 1'b1;
                    mem_drive  = 1'b1;
                    inputReady = (strobes == v.wait_n + 1);
                    mem_data   = inputReady ? v.mem_rdata : 16'hDEAD;
                end
            end
        end
        if_req = 1'b0; d_req = 1'b0;
        if (cyc >= 40) begin
            check("access completion timeout", 32'd1, 32'd0);
        end else begin
            check_done("access");
            check("strobe cycles", strobes, v.strobes);
        end
        @(negedge clk);
        check("pulse one cycle", {29'd0, if_done, d_done, err}, 32'd0);
        check("idle after access", {30'd0, busy, readM | writeM}, 32'd0);
        if (wr) check("bus released", {31'd0, data !== v.wdata}, 32'd1);
    endtask

    initial begin
        int cyc;
        int rr_count;
        exp_t e;

        vecs[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h6A05, 3,  3'b100, 16'h6A05, 16'd1, 4};
        vecs[1] = '{1'b1, 1'b1, 16'h00C0, 16'hBEEF, 16'h0000, 2,  3'b010, 16'h6A05, 16'd2, 3};
        vecs[2] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0F0F, 0,  3'b010, 16'h0F0F, 16'd3, 1};
        vecs[3] = '{1'b1, 1'b0, 16'h4000, 16'h0000, 16'h1111, 99, 3'b001, 16'h0F0F, 16'd3, 4};
        vecs[4] = '{1'b0, 1'b0, 16'hFFFE, 16'h0000, 16'hA5A5, 3,  3'b100, 16'hA5A5, 16'd4, 4};
        vecs[5] = '{1'b1, 1'b1, 16'h0042, 16'h1357, 16'h0000, 99, 3'b001, 16'hA5A5, 16'd4, 4};
        vecs[6] = '{1'b0, 1'b0, 16'h0002, 16'h0000, 16'h2222, 4,  3'b001, 16'hA5A5, 16'd4, 4};
        vecs[7] = '{1'b1, 1'b1, 16'h0001, 16'h7777, 16'h0000, 0,  3'b010, 16'hA5A5, 16'd5, 1};

        reset = 1'b1;
        if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        inputReady = 1'b0; ackOutput = 1'b0; mem_drive = 1'b0; mem_data = '0;
        rr_if_req = 1'b0; rr_d_req = 1'b0;
        repeat (2) @(negedge clk);
        check("reset strobes/busy", {29'd0, readM, writeM, busy}, 32'd0);
        check("reset pulses", {29'd0, if_done, d_done, err}, 32'd0);
        check("reset address", {16'd0, address}, 32'd0);
        check("reset rdata/num", {rdata, num_access}, 32'd0);
        reset = 1'b0;

        foreach (vecs[i]) run_access(vecs[i]);

        // Tie with data priority: data first, then the still-held fetch.
        @(negedge clk);
        if_req = 1'b1; if_addr = 16'h0100;
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
        exp_q.push_back('{kind: 3'b010, rdata: 16'h5755, num: 16'd6});
        exp_q.push_back('{kind: 3'b100, rdata: 16'h5455, num: 16'd7});
        cyc = 0;
        while (exp_q.size() > 0 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            mem_drive = readM; mem_data = address ^ 16'h5555; inputReady = readM;
            if (if_done || d_done || err) begin
                if (d_done) d_req = 1'b0;
                if (if_done) if_req = 1'b0;
                check_done("tie");
            end
        end
        if_req = 1'b0; d_req = 1'b0; mem_drive = 1'b0; inputReady = 1'b0;
        check("tie completion", exp_q.size(), 0);
        exp_q.delete();

        // Reset in the middle of a stalled data read.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0300;
        repeat (2) @(negedge clk);
        check("pre-reset readM", {31'd0, readM}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; d_req = 1'b0;
        check("mid reset strobe/busy", {29'd0, readM, writeM, busy}, 32'd0);
        check("mid reset num/rdata", {num_access, rdata}, 32'd0);
        check("mid reset address", {16'd0, address}, 32'd0);
        @(negedge clk);
        check("mid reset no done", {29'd0, if_done, d_done, err}, 32'd0);

        // Round-robin ties on a 4-bit instance: D,I,D,I... and num_access wraps after 16.
        for (int i = 0; i < 16; i++) begin
            rr_q.push_back('{kind: (i % 2 == 0) ? 3'b010 : 3'b100,
                             rdata: (i % 2 == 0) ? 16'h6 : 16'hC,
                             num: 16'((i + 1) % 16)});
        end
        @(negedge clk);
        rr_if_req = 1'b1; rr_d_req = 1'b1;
        rr_count = 0;
        cyc = 0;
        while (rr_count < 16 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (rr_if_done || rr_d_done || rr_err) begin
                e = rr_q.pop_front();
                rr_count++;
                check("rr kind", {29'd0, rr_if_done, rr_d_done, rr_err}, {29'd0, e.kind});
                check("rr rdata", {28'd0, rr_rdata}, {16'd0, e.rdata});
                check("rr num_access", {28'd0, rr_num}, {16'd0, e.num});
                if (rr_count == 16) begin
                    rr_if_req = 1'b0; rr_d_req = 1'b0;
                end
            end
        end
        rr_if_req = 1'b0; rr_d_req = 1'b0;
        check("rr completion", rr_count, 16);
        @(negedge clk);
        check("rr idle after wrap", {31'd0, rr_busy}, 32'd0);
        check("rr wrapped count", {28'd0, rr_num}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
